// File: rtl/hex_count_ctrl.sv
// hex_count_ctrl: tick-driven 16-bit up/down hex counter with debounced
// pause/direction/clear buttons and a leading-zero blank mask.
//
// Ports:
//   clk        system clock (fast clock shared with divider and display)
//   rst        asynchronous active-high reset
//   tick_in    slow clock level; one count step per rising edge
//   btn_pause  raw button, each press toggles run/pause
//   btn_dir    raw button, each press toggles up/down
//   btn_clear  raw button, each press zeroes the count
//   count      current count, nibble 3 is the leftmost digit
//   blank      per-digit blank mask, bit i=1 blanks digit i
//   running    1 = counting enabled
//   dir_up     1 = count up, 0 = count down
//   wrap_pulse one-cycle pulse on a wrap-around step
module hex_count_ctrl #(
    parameter int          DEBOUNCE_CYCLES = 120_000,
    parameter logic [15:0] MAX_COUNT       = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_in,
    input  logic        btn_pause,
    input  logic        btn_dir,
    input  logic        btn_clear,
    output logic [15:0] count,
    output logic [3:0]  blank,
    output logic        running,
    output logic        dir_up,
    output logic        wrap_pulse
);

    localparam int DC_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DC_W-1:0] DC_LAST = DC_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DC_W-1:0] DC_ONE  = DC_W'(1);

    // Button lanes: 0 = pause, 1 = dir, 2 = clear
    localparam int B_PAUSE = 0;
    localparam int B_DIR   = 1;
    localparam int B_CLEAR = 2;

    logic            t1;
    logic            t2;
    logic            step;
    logic [2:0]      raw;
    logic [2:0]      s1;
    logic [2:0]      s2;
    logic [2:0]      db;
    logic [2:0]      db_q;
    logic [2:0]      press;
    logic [DC_W-1:0] dc [3];
    logic [15:0]     count_nxt;
    logic            wrap_nxt;

    assign raw   = {btn_clear, btn_dir, btn_pause};
    assign press = db & ~db_q;
    assign step  = t1 & ~t2 & running;

    // Tick edge detector
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t1 <= 1'b0;
            t2 <= 1'b0;
        end else begin
            t1 <= tick_in;
            t2 <= t1;
        end
    end

    // Synchronizers and debouncers; any mismatch shorter than
    // DEBOUNCE_CYCLES is forgotten as soon as the level returns.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= '0;
            s2   <= '0;
            db   <= '0;
            db_q <= '0;
            for (int i = 0; i < 3; i++) begin
                dc[i] <= '0;
            end
        end else begin
            s1   <= raw;
            s2   <= s1;
            db_q <= db;
            for (int i = 0; i < 3; i++) begin
                if (s2[i] == db[i]) begin
                    dc[i] <= '0;
                end else if (dc[i] == DC_LAST) begin
                    db[i] <= s2[i];
                    dc[i] <= '0;
                end else begin
                    dc[i] <= dc[i] + DC_ONE;
                end
            end
        end
    end

    // Clear wins over a coincident step
    always_comb begin
        count_nxt = count;
        wrap_nxt  = 1'b0;
        if (press[B_CLEAR]) begin
            count_nxt = '0;
        end else if (step) begin
            if (dir_up) begin
                if (count == MAX_COUNT) begin
                    count_nxt = '0;
                    wrap_nxt  = 1'b1;
                end else begin
                    count_nxt = count + 16'd1;
                end
            end else begin
                if (count == '0) begin
                    count_nxt = MAX_COUNT;
                    wrap_nxt  = 1'b1;
                end else begin
                    count_nxt = count - 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= '0;
            wrap_pulse <= 1'b0;
            running    <= 1'b1;
            dir_up     <= 1'b1;
        end else begin
            count      <= count_nxt;
            wrap_pulse <= wrap_nxt;
            if (press[B_PAUSE]) begin
                running <= ~running;
            end
            if (press[B_DIR]) begin
                dir_up <= ~dir_up;
            end
        end
    end

    // Digit 0 always shows; higher digits blank while all digits
    // from the left down to them are zero.
    assign blank[0] = 1'b0;
    assign blank[1] = (count[15:4] == '0);
    assign blank[2] = (count[15:8] == '0);
    assign blank[3] = (count[15:12] == '0);

endmodule

// File: tb/tb_hex_count_ctrl.sv
// tb_hex_count_ctrl: scoreboard bench for hex_count_ctrl with a short
// debounce window; expected counts come from a small behavioural model.
module tb_hex_count_ctrl;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick_in = 1'b0;
    logic        btn_pause = 1'b0;
    logic        btn_dir = 1'b0;
    logic        btn_clear = 1'b0;
    logic [15:0] count;
    logic [3:0]  blank;
    logic        running;
    logic        dir_up;
    logic        wrap_pulse;

    typedef struct packed {
        logic [15:0] c;
        logic        w;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [15:0] m_count = 16'h0000;
    logic        m_run = 1'b1;
    logic        m_dir = 1'b1;

    hex_count_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .MAX_COUNT(16'hFFFF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tick_in(tick_in),
        .btn_pause(btn_pause),
        .btn_dir(btn_dir),
        .btn_clear(btn_clear),
        .count(count),
        .blank(blank),
        .running(running),
        .dir_up(dir_up),
        .wrap_pulse(wrap_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [3:0] blank_of(input logic [15:0] v);
        logic [3:0] b;
        b[0] = 1'b0;
        b[1] = (v < 16'h0010);
        b[2] = (v < 16'h0100);
        b[3] = (v < 16'h1000);
        return b;
    endfunction

    function automatic exp_t model_step();
        exp_t e;
        e.w = 1'b0;
        if (m_run) begin
            if (m_dir) begin
                e.w = (m_count == 16'hFFFF);
                m_count = m_count + 16'd1;
            end else begin
                e.w = (m_count == 16'h0000);
                m_count = m_count - 16'd1;
            end
        end
        e.c = m_count;
        return e;
    endfunction

    task automatic model_reset();
        m_count = 16'h0000;
        m_run = 1'b1;
        m_dir = 1'b1;
        sb.delete();
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input int which, input logic v);
        case (which)
            0: btn_pause = v;
            1: btn_dir = v;
            default: btn_clear = v;
        endcase
    endtask

    task automatic tick(input bit chk);
        exp_t        e;
        logic [15:0] old;
        @(negedge clk);
        tick_in = 1'b1;
        old = m_count;
        e = model_step();
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (chk) begin
            tests++;
            if (count !== old || wrap_pulse !== 1'b0) begin
                fails++;
                $display("FAIL tick_latency: count=%h wrap=%b want %h/0",
                         count, wrap_pulse, old);
            end
        end
        @(negedge clk);
        tick_in = 1'b0;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (chk) begin
            tests++;
            if (count !== e.c || wrap_pulse !== e.w ||
                blank !== blank_of(e.c)) begin
                fails++;
                $display("FAIL tick_step: count=%h wrap=%b blank=%b want %h/%b/%b",
                         count, wrap_pulse, blank, e.c, e.w, blank_of(e.c));
            end
        end
    endtask

    task automatic press_btn(input int which);
        logic got;
        logic want;
        @(negedge clk);
        set_btn(which, 1'b1);
        edges(D + 3);
        if (which == 0) begin
            m_run = ~m_run;
            got = running;
            want = m_run;
        end else begin
            m_dir = ~m_dir;
            got = dir_up;
            want = m_dir;
        end
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL press_btn%0d: state=%b want %b", which, got, want);
        end
        @(negedge clk);
        set_btn(which, 1'b0);
        edges(D + 6);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        edges(2);
        @(negedge clk);
        rst = 1'b0;
        edges(1);
        tests++;
        if (count !== 16'h0 || running !== 1'b1 || dir_up !== 1'b1) begin
            fails++;
            $display("FAIL do_reset: count=%h run=%b dir=%b want 0000/1/1",
                     count, running, dir_up);
        end
    endtask

    task automatic test_reset();
        edges(2);
        tests++;
        if (count !== 16'h0 || blank !== 4'b1110 || running !== 1'b1 ||
            dir_up !== 1'b1 || wrap_pulse !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: count=%h blank=%b run=%b dir=%b wrap=%b",
                     count, blank, running, dir_up, wrap_pulse);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        edges(3);
        tests++;
        if (count !== 16'h0 || wrap_pulse !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: count=%h wrap=%b want 0000/0",
                     count, wrap_pulse);
        end
    endtask

    task automatic test_tick_count();
        repeat (3) tick(1'b1);
        tests++;
        if (count !== 16'h0003 || blank !== 4'b1110) begin
            fails++;
            $display("FAIL tick_count: count=%h blank=%b want 0003/1110",
                     count, blank);
        end
    endtask

    task automatic test_dir();
        do_reset();
        repeat (2) tick(1'b1);
        @(negedge clk);
        btn_dir = 1'b1;
        edges(6);
        tests++;
        if (dir_up !== 1'b1) begin
            fails++;
            $display("FAIL dir_early: dir_up=%b want 1 at edge 6", dir_up);
        end
        edges(1);
        m_dir = 1'b0;
        tests++;
        if (dir_up !== 1'b0) begin
            fails++;
            $display("FAIL dir_edge7: dir_up=%b want 0", dir_up);
        end
        @(negedge clk);
        btn_dir = 1'b0;
        edges(D + 6);
        tests++;
        if (dir_up !== 1'b0) begin
            fails++;
            $display("FAIL dir_release: dir_up=%b want 0", dir_up);
        end
        repeat (3) tick(1'b1);
    endtask

    task automatic test_wrap();
        tick(1'b1);
        press_btn(1);
        repeat (2) tick(1'b1);
        edges(1);
        tests++;
        if (wrap_pulse !== 1'b0 || count !== 16'h0000) begin
            fails++;
            $display("FAIL wrap_single: wrap=%b count=%h want 0/0000",
                     wrap_pulse, count);
        end
    endtask

    task automatic test_pause_bounce();
        @(negedge clk);
        btn_pause = 1'b1;
        repeat (2) @(negedge clk);
        btn_pause = 1'b0;
        repeat (2) @(negedge clk);
        btn_pause = 1'b1;
        edges(6);
        tests++;
        if (running !== 1'b1) begin
            fails++;
            $display("FAIL pause_early: running=%b want 1", running);
        end
        edges(1);
        m_run = 1'b0;
        tests++;
        if (running !== 1'b0) begin
            fails++;
            $display("FAIL pause_toggle: running=%b want 0", running);
        end
        repeat (2) tick(1'b1);
        @(negedge clk);
        btn_pause = 1'b0;
        edges(D + 6);
        tests++;
        if (running !== 1'b0) begin
            fails++;
            $display("FAIL pause_release: running=%b want 0", running);
        end
        press_btn(0);
        edges(3);
        tests++;
        if (count !== m_count) begin
            fails++;
            $display("FAIL resume_nodefer: count=%h want %h", count, m_count);
        end
        tick(1'b1);
    endtask

    task automatic test_clear();
        while (m_count != 16'h00A5) tick(1'b0);
        tests++;
        if (count !== 16'h00A5 || blank !== 4'b1100) begin
            fails++;
            $display("FAIL preload_a5: count=%h blank=%b want 00a5/1100",
                     count, blank);
        end
        @(negedge clk);
        btn_clear = 1'b1;
        edges(5);
        @(negedge clk);
        tick_in = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (count !== 16'h00A5) begin
            fails++;
            $display("FAIL clear_early: count=%h want 00a5", count);
        end
        @(negedge clk);
        tick_in = 1'b0;
        @(posedge clk);
        #1;
        m_count = 16'h0000;
        tests++;
        if (count !== 16'h0000 || wrap_pulse !== 1'b0 || blank !== 4'b1110) begin
            fails++;
            $display("FAIL clear_step: count=%h wrap=%b blank=%b want 0000/0/1110",
                     count, wrap_pulse, blank);
        end
        @(negedge clk);
        btn_clear = 1'b0;
        edges(D + 6);
        tests++;
        if (count !== 16'h0000) begin
            fails++;
            $display("FAIL clear_hold: count=%h want 0000", count);
        end
    endtask

    task automatic test_reset_mid();
        while (m_count != 16'h0A05) tick(1'b0);
        tests++;
        if (count !== 16'h0A05 || blank !== 4'b1000) begin
            fails++;
            $display("FAIL blank_0a05: count=%h blank=%b want 0a05/1000",
                     count, blank);
        end
        while (m_count != 16'h1000) tick(1'b0);
        tests++;
        if (count !== 16'h1000 || blank !== 4'b0000) begin
            fails++;
            $display("FAIL blank_1000: count=%h blank=%b want 1000/0000",
                     count, blank);
        end
        while (m_count != 16'h1234) tick(1'b0);
        @(negedge clk);
        btn_dir = 1'b1;
        edges(4);
        #2;
        rst = 1'b1;
        tick_in = 1'b1;
        model_reset();
        #1;
        tests++;
        if (count !== 16'h0 || running !== 1'b1 || dir_up !== 1'b1 ||
            wrap_pulse !== 1'b0 || blank !== 4'b1110) begin
            fails++;
            $display("FAIL async_reset: count=%h run=%b dir=%b wrap=%b blank=%b",
                     count, running, dir_up, wrap_pulse, blank);
        end
        edges(2);
        @(negedge clk);
        rst = 1'b0;
        edges(1);
        tests++;
        if (count !== 16'h0000) begin
            fails++;
            $display("FAIL held_tick_e1: count=%h want 0000", count);
        end
        edges(1);
        m_count = 16'h0001;
        tests++;
        if (count !== 16'h0001) begin
            fails++;
            $display("FAIL held_tick_e2: count=%h want 0001", count);
        end
        edges(4);
        tests++;
        if (dir_up !== 1'b1) begin
            fails++;
            $display("FAIL held_btn_e6: dir_up=%b want 1", dir_up);
        end
        edges(1);
        m_dir = 1'b0;
        tests++;
        if (dir_up !== 1'b0 || count !== 16'h0001) begin
            fails++;
            $display("FAIL held_btn_e7: dir_up=%b count=%h want 0/0001",
                     dir_up, count);
        end
        @(negedge clk);
        btn_dir = 1'b0;
        tick_in = 1'b0;
        edges(D + 6);
        tests++;
        if (count !== 16'h0001 || dir_up !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_hold: count=%h dir_up=%b want 0001/0",
                     count, dir_up);
        end
    endtask

    initial begin
        test_reset();
        test_tick_count();
        test_dir();
        test_wrap();
        test_pause_bounce();
        test_clear();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
